// File: rtl/mem_dbus_ctrl.sv
// Data-bus controller: turns a mem-stage access into a cyc/stb/ack bus cycle.
// Latency: request cycle + bus wait states. The pipeline is stalled until ack, flush or timeout.
module mem_dbus_ctrl #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_ce_i,
  input  logic        cpu_we_i,
  input  logic [31:0] cpu_addr_i,
  input  logic [3:0]  cpu_sel_i,
  input  logic [31:0] cpu_data_i,
  output logic [31:0] cpu_data_o,
  output logic        stallreq_o,
  input  logic        stall_i,
  input  logic        flush_i,
  output logic        bus_cyc_o,
  output logic        bus_stb_o,
  output logic        bus_we_o,
  output logic [31:0] bus_adr_o,
  output logic [3:0]  bus_sel_o,
  output logic [31:0] bus_dat_o,
  input  logic [31:0] bus_dat_i,
  input  logic        bus_ack_i,
  output logic        bus_err_o
);

  localparam int CW = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_HOLD} state_t;

  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic [31:0]   r_buf;
  logic          r_cyc;
  logic          r_we;
  logic [31:0]   r_adr;
  logic [3:0]    r_sel;
  logic [31:0]   r_dat;
  logic          r_err;
  logic          w_tmo;

  assign w_tmo = (TIMEOUT != 0) && (r_cnt == CW'(TIMEOUT - 1));

  always_comb begin
    stallreq_o = 1'b0;
    cpu_data_o = 32'h0;
    case (r_state)
      S_IDLE: stallreq_o = cpu_ce_i & ~flush_i;
      S_BUSY: begin
        if (!flush_i) begin
          if (bus_ack_i)   cpu_data_o = bus_dat_i;
          else if (!w_tmo) stallreq_o = 1'b1;
        end
      end
      S_HOLD: cpu_data_o = r_buf;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_buf   <= 32'h0;
      r_cyc   <= 1'b0;
      r_we    <= 1'b0;
      r_adr   <= 32'h0;
      r_sel   <= 4'h0;
      r_dat   <= 32'h0;
      r_err   <= 1'b0;
    end else begin
      r_err <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (cpu_ce_i && !flush_i) begin
            r_cyc   <= 1'b1;
            r_we    <= cpu_we_i;
            r_adr   <= cpu_addr_i;
            r_sel   <= cpu_sel_i;
            r_dat   <= cpu_data_i;
            r_cnt   <= '0;
            r_state <= S_BUSY;
          end
        end
        S_BUSY: begin
          if (flush_i) begin
            r_cyc   <= 1'b0;
            r_we    <= 1'b0;
            r_state <= S_IDLE;
          end else if (bus_ack_i) begin
            r_cyc   <= 1'b0;
            r_we    <= 1'b0;
            r_buf   <= bus_dat_i;
            r_state <= stall_i ? S_HOLD : S_IDLE;
          end else if (w_tmo) begin
            // Aborted loads present zero if the mem stage is held afterwards.
            r_cyc   <= 1'b0;
            r_we    <= 1'b0;
            r_err   <= 1'b1;
            r_buf   <= 32'h0;
            r_state <= stall_i ? S_HOLD : S_IDLE;
          end else if (r_cnt != '1) begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        S_HOLD: begin
          if (!stall_i || flush_i) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus_cyc_o = r_cyc;
  assign bus_stb_o = r_cyc;
  assign bus_we_o  = r_we;
  assign bus_adr_o = r_adr;
  assign bus_sel_o = r_sel;
  assign bus_dat_o = r_dat;
  assign bus_err_o = r_err;

endmodule

// File: tb/tb_mem_dbus_ctrl.sv
// Bench for mem_dbus_ctrl: directed accesses, with a monitor checking bus requests,
// load responses and error pulses against queues filled by the stimulus.
module tb_mem_dbus_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_ce_i, cpu_we_i, stall_i, flush_i, bus_ack_i;
  logic [31:0] cpu_addr_i, cpu_data_i, bus_dat_i;
  logic [3:0]  cpu_sel_i;
  logic [31:0] cpu_data_o, bus_adr_o, bus_dat_o;
  logic        stallreq_o, bus_cyc_o, bus_stb_o, bus_we_o, bus_err_o;
  logic [3:0]  bus_sel_o;

  mem_dbus_ctrl #(.TIMEOUT(4)) dut (
    .clk(clk), .rst(rst),
    .cpu_ce_i(cpu_ce_i), .cpu_we_i(cpu_we_i), .cpu_addr_i(cpu_addr_i),
    .cpu_sel_i(cpu_sel_i), .cpu_data_i(cpu_data_i), .cpu_data_o(cpu_data_o),
    .stallreq_o(stallreq_o), .stall_i(stall_i), .flush_i(flush_i),
    .bus_cyc_o(bus_cyc_o), .bus_stb_o(bus_stb_o), .bus_we_o(bus_we_o),
    .bus_adr_o(bus_adr_o), .bus_sel_o(bus_sel_o), .bus_dat_o(bus_dat_o),
    .bus_dat_i(bus_dat_i), .bus_ack_i(bus_ack_i), .bus_err_o(bus_err_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [31:0] adr;
    logic [3:0]  sel;
    logic [31:0] dat;
  } req_t;

  req_t        q_req[$];
  logic [31:0] q_rsp[$];
  int          q_err[$];
  int          n_tot = 0;
  int          n_bad = 0;
  logic        m_prev_cyc = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (bus_cyc_o && !m_prev_cyc) begin
        if (q_req.size() == 0) begin
          n_tot++; n_bad++;
          $display("FAIL mon_spurious_cyc: got adr %h want no access", bus_adr_o);
        end else begin
          req_t r;
          r = q_req.pop_front();
          chk("mon_we",  bus_we_o,  r.we);
          chk("mon_adr", bus_adr_o, r.adr);
          chk("mon_sel", bus_sel_o, r.sel);
          if (r.we) chk("mon_wdat", bus_dat_o, r.dat);
          chk("mon_stb", bus_stb_o, 1'b1);
        end
      end
      if (bus_cyc_o && bus_ack_i && !flush_i) begin
        if (q_rsp.size() == 0) begin
          n_tot++; n_bad++;
          $display("FAIL mon_unexpected_ack: got ack want none");
        end else begin
          logic [31:0] e;
          e = q_rsp.pop_front();
          chk("mon_rdata", cpu_data_o, e);
          chk("mon_ack_stall", stallreq_o, 1'b0);
        end
      end
      if (bus_err_o) begin
        if (q_err.size() == 0) begin
          n_tot++; n_bad++;
          $display("FAIL mon_spurious_err: got err=1 want 0");
        end else begin
          void'(q_err.pop_front());
        end
      end
    end
    m_prev_cyc = bus_cyc_o;
  end

  // Load or store acked in BUSY cycle number `waits` (0 = first), stall_i low.
  task automatic access(input logic we, input logic [31:0] adr, input logic [3:0] sel,
                        input logic [31:0] wd, input int waits, input logic [31:0] rd,
                        input string tag);
    int n_st, n_cy;
    req_t r;
    n_st = 0; n_cy = 0;
    step();
    cpu_ce_i = 1'b1; cpu_we_i = we; cpu_addr_i = adr; cpu_sel_i = sel; cpu_data_i = wd;
    r.we = we; r.adr = adr; r.sel = sel; r.dat = wd;
    q_req.push_back(r);
    @(negedge clk);
    n_st += int'(stallreq_o); n_cy += int'(bus_cyc_o);
    for (int i = 0; i <= waits; i++) begin
      step();
      cpu_addr_i = ~adr; cpu_data_i = 32'h0; cpu_sel_i = ~sel;
      if (i == waits) begin
        bus_ack_i = 1'b1; bus_dat_i = rd;
        q_rsp.push_back(rd);
      end
      @(negedge clk);
      n_st += int'(stallreq_o); n_cy += int'(bus_cyc_o);
      if (bus_cyc_o) chk({tag, "_adr_held"}, bus_adr_o, adr);
    end
    step();
    bus_ack_i = 1'b0; cpu_ce_i = 1'b0;
    @(negedge clk);
    chk({tag, "_cyc_after"}, bus_cyc_o, 1'b0);
    chk({tag, "_stall_after"}, stallreq_o, 1'b0);
    chk({tag, "_data_idle"}, cpu_data_o, 32'h0);
    chk({tag, "_n_stall"}, n_st, waits + 1);
    chk({tag, "_n_cyc"}, n_cy, waits + 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish want finish before 200us");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    req_t r;
    rst = 1'b1;
    cpu_ce_i = 0; cpu_we_i = 0; cpu_addr_i = 0; cpu_sel_i = 0; cpu_data_i = 0;
    stall_i = 0; flush_i = 0; bus_ack_i = 0; bus_dat_i = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_cyc", bus_cyc_o, 1'b0);
    chk("rst_we", bus_we_o, 1'b0);
    chk("rst_adr", bus_adr_o, 32'h0);
    chk("rst_err", bus_err_o, 1'b0);
    chk("rst_stall", stallreq_o, 1'b0);
    chk("rst_data", cpu_data_o, 32'h0);
    rst = 1'b0;

    // 1: load, acked in fourth BUSY cycle
    access(1'b0, 32'h80, 4'hF, 32'h0, 3, 32'hDEADBEEF, "t1");

    // 2: byte store acked immediately, then no reissue
    access(1'b1, 32'h103, 4'h1, 32'h55555555, 0, 32'h0000_0000, "t2");
    for (int i = 0; i < 2; i++) begin
      step();
      @(negedge clk);
      chk("t2_no_reissue", bus_cyc_o, 1'b0);
    end

    // 3: flush in second BUSY cycle, late ack ignored
    step();
    cpu_ce_i = 1; cpu_we_i = 0; cpu_addr_i = 32'h200; cpu_sel_i = 4'hF;
    r.we = 0; r.adr = 32'h200; r.sel = 4'hF; r.dat = 0;
    q_req.push_back(r);
    @(negedge clk);
    chk("t3_req_stall", stallreq_o, 1'b1);
    step();
    @(negedge clk);
    chk("t3_busy1_stall", stallreq_o, 1'b1);
    step();
    flush_i = 1'b1;
    @(negedge clk);
    chk("t3_flush_stall", stallreq_o, 1'b0);
    chk("t3_flush_data", cpu_data_o, 32'h0);
    step();
    flush_i = 1'b0; cpu_ce_i = 1'b0; bus_ack_i = 1'b1; bus_dat_i = 32'h0BAD0BAD;
    @(negedge clk);
    chk("t3_cyc_dropped", bus_cyc_o, 1'b0);
    chk("t3_late_ack_data", cpu_data_o, 32'h0);
    chk("t3_late_ack_stall", stallreq_o, 1'b0);
    step();
    bus_ack_i = 1'b0;
    @(negedge clk);
    chk("t3_idle_cyc", bus_cyc_o, 1'b0);

    // 4: ack while the mem stage is stalled, data held, no new access
    step();
    cpu_ce_i = 1; cpu_we_i = 0; cpu_addr_i = 32'h300; cpu_sel_i = 4'hF;
    r.we = 0; r.adr = 32'h300; r.sel = 4'hF; r.dat = 0;
    q_req.push_back(r);
    @(negedge clk);
    step();
    bus_ack_i = 1'b1; bus_dat_i = 32'h12345678; stall_i = 1'b1;
    q_rsp.push_back(32'h12345678);
    @(negedge clk);
    step();
    bus_ack_i = 1'b0; bus_dat_i = 32'h0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t4_hold_data", cpu_data_o, 32'h12345678);
      chk("t4_hold_cyc", bus_cyc_o, 1'b0);
      chk("t4_hold_stall", stallreq_o, 1'b0);
      step();
    end
    stall_i = 1'b0;
    @(negedge clk);
    chk("t4_release_data", cpu_data_o, 32'h12345678);
    cpu_ce_i = 1'b0;
    access(1'b0, 32'h304, 4'hF, 32'h0, 1, 32'hCAFEF00D, "t4b");

    // 5: never acked, abort after four BUSY cycles
    step();
    cpu_ce_i = 1; cpu_we_i = 0; cpu_addr_i = 32'h400; cpu_sel_i = 4'hF;
    r.we = 0; r.adr = 32'h400; r.sel = 4'hF; r.dat = 0;
    q_req.push_back(r);
    q_err.push_back(1);
    @(negedge clk);
    chk("t5_req_stall", stallreq_o, 1'b1);
    n = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      @(negedge clk);
      n += int'(bus_cyc_o);
      chk("t5_busy_stall", stallreq_o, (i < 3) ? 1'b1 : 1'b0);
      chk("t5_busy_err", bus_err_o, 1'b0);
    end
    chk("t5_n_cyc", n, 4);
    step();
    cpu_ce_i = 1'b0;
    @(negedge clk);
    chk("t5_cyc_off", bus_cyc_o, 1'b0);
    chk("t5_err_pulse", bus_err_o, 1'b1);
    chk("t5_stall_off", stallreq_o, 1'b0);
    step();
    @(negedge clk);
    chk("t5_err_one_cycle", bus_err_o, 1'b0);

    // 6: asynchronous reset in the middle of a store
    step();
    cpu_ce_i = 1; cpu_we_i = 1; cpu_addr_i = 32'h500; cpu_sel_i = 4'h3; cpu_data_i = 32'hA5A5A5A5;
    r.we = 1; r.adr = 32'h500; r.sel = 4'h3; r.dat = 32'hA5A5A5A5;
    q_req.push_back(r);
    @(negedge clk);
    step();
    @(negedge clk);
    chk("t6_busy_cyc", bus_cyc_o, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    chk("t6_async_cyc", bus_cyc_o, 1'b0);
    chk("t6_async_stb", bus_stb_o, 1'b0);
    chk("t6_async_we", bus_we_o, 1'b0);
    chk("t6_async_err", bus_err_o, 1'b0);
    cpu_ce_i = 1'b0;
    step();
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      @(negedge clk);
      chk("t6_idle_cyc", bus_cyc_o, 1'b0);
      chk("t6_idle_stall", stallreq_o, 1'b0);
    end

    chk("end_req_queue", q_req.size(), 0);
    chk("end_rsp_queue", q_rsp.size(), 0);
    chk("end_err_queue", q_err.size(), 0);
    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule
